// File: rtl/de_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// de_hazard_ctrl
//
// Hazard and stall controller for the reader side of the decode/execute
// pipeline register. It compares the instruction in EX (the DE register
// output) with the instruction in decode and drives the stall, bubble and
// flush controls for the front of the pipe. It handles load-use hazards,
// which may need several bubble cycles, taken-branch redirects, and
// data-memory wait. Two saturating event counters support performance debug.
//
// Parameters
//   OP_BUBBLE    opcode the DE register loads as a no-op
//   OP_LW        load-word opcode; its destination is the rt field
//   LOAD_STALLS  bubble cycles per load-use hazard, 1..3
//   CNT_W        width of each performance counter
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        synchronous reset, active-high
//   i_id_rs      rs field of the decode instruction
//   i_id_rt      rt field of the decode instruction
//   i_id_use_rt  decode instruction reads rt as a source
//   i_ex_op      opcode held in the DE register
//   i_ex_rt      rt field held in the DE register
//   i_ex_taken   EX instruction redirects the PC this cycle
//   i_mem_busy   data memory wait, whole pipe freezes
//   o_pc_stall   hold the PC and the IF/ID register
//   o_de_bubble  DE register loads OP_BUBBLE instead of op_in
//   o_fd_flush   IF/ID register loads a bubble
//   o_pipe_hold  DE and later registers keep their contents
//   o_stall_cnt  load-use bubble cycles since reset, saturating
//   o_flush_cnt  taken-branch flush events since reset, saturating
// -----------------------------------------------------------------------------
module de_hazard_ctrl #(
    parameter logic [5:0] OP_BUBBLE   = 6'b110111,
    parameter logic [5:0] OP_LW       = 6'b010000,
    parameter int         LOAD_STALLS = 1,
    parameter int         CNT_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [4:0]       i_id_rs,
    input  logic [4:0]       i_id_rt,
    input  logic             i_id_use_rt,
    input  logic [5:0]       i_ex_op,
    input  logic [4:0]       i_ex_rt,
    input  logic             i_ex_taken,
    input  logic             i_mem_busy,
    output logic             o_pc_stall,
    output logic             o_de_bubble,
    output logic             o_fd_flush,
    output logic             o_pipe_hold,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    // OP_BUBBLE is the value the DE register itself loads; this block only
    // requests the bubble, so the opcode is not referenced here.
    localparam logic [5:0] UNUSED_BUBBLE_OP = OP_BUBBLE;

    state_t           r_state;
    state_t           w_next_state;
    logic [1:0]       r_rem;
    logic [1:0]       w_next_rem;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_hazard;
    logic             w_stall_inc;
    logic             w_flush_inc;

    // Register $zero never carries a real dependency, so a load into r0 is
    // ignored. The rt comparison only matters when decode actually reads rt.
    assign w_hazard = (i_ex_op == OP_LW) && (i_ex_rt != 5'd0) &&
                      ((i_id_rs == i_ex_rt) ||
                       (i_id_use_rt && (i_id_rt == i_ex_rt)));

    // Next-state and control outputs. Priority is reset, then memory wait,
    // then branch redirect, then load-use hazard. A taken branch in STALL
    // aborts the remaining bubbles because the decode instruction is being
    // thrown away anyway.
    always_comb begin
        o_pc_stall   = 1'b0;
        o_de_bubble  = 1'b0;
        o_fd_flush   = 1'b0;
        o_pipe_hold  = 1'b0;
        w_stall_inc  = 1'b0;
        w_flush_inc  = 1'b0;
        w_next_state = r_state;
        w_next_rem   = r_rem;

        if (i_rst) begin
            o_de_bubble = 1'b1;
            o_fd_flush  = 1'b1;
        end else if (i_mem_busy) begin
            o_pipe_hold = 1'b1;
            o_pc_stall  = 1'b1;
        end else if (i_ex_taken) begin
            o_fd_flush   = 1'b1;
            o_de_bubble  = 1'b1;
            w_flush_inc  = 1'b1;
            w_next_state = ST_RUN;
            w_next_rem   = 2'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_hazard) begin
                        o_pc_stall  = 1'b1;
                        o_de_bubble = 1'b1;
                        w_stall_inc = 1'b1;
                        if (LOAD_STALLS > 1) begin
                            w_next_state = ST_STALL;
                            w_next_rem   = 2'(LOAD_STALLS - 1);
                        end
                    end
                end
                ST_STALL: begin
                    // Hazard detection is ignored here: the bubble count was
                    // fixed when the hazard was first seen.
                    o_pc_stall  = 1'b1;
                    o_de_bubble = 1'b1;
                    w_stall_inc = 1'b1;
                    w_next_rem  = r_rem - 2'd1;
                    if (r_rem == 2'd1) begin
                        w_next_state = ST_RUN;
                    end
                end
                default: begin
                    w_next_state = ST_RUN;
                    w_next_rem   = 2'd0;
                end
            endcase
        end
    end

    // State and remaining-bubble register. During a memory wait the
    // combinational block leaves next state equal to current state, which
    // freezes the stall sequence.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_RUN;
            r_rem   <= 2'd0;
        end else begin
            r_state <= w_next_state;
            r_rem   <= w_next_rem;
        end
    end

    // Saturating performance counters; they stop at all-ones rather than wrap.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_inc && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush_inc && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_de_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_de_hazard_ctrl
//
// Three controller instances share one set of inputs: LOAD_STALLS=1,
// LOAD_STALLS=3, and LOAD_STALLS=1 with 4-bit counters. A vector table
// exercises the single-cycle behaviour; hand-written sequences cover the
// multi-cycle stall, abort, memory-wait freeze, reset mid-stall and
// counter saturation.
// -----------------------------------------------------------------------------
module tb_de_hazard_ctrl;

    localparam logic [5:0] OP_B  = 6'b110111;
    localparam logic [5:0] OP_L  = 6'b010000;
    localparam logic [5:0] OP_AD = 6'b000000;

    typedef struct {
        string      name;
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       useRt;
        logic [5:0] op;
        logic [4:0] exRt;
        logic       taken;
        logic       busy;
        logic       expPc;
        logic       expBub;
        logic       expFl;
        logic       expHold;
        int         expStall;
        int         expFlush;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  idRs = '0;
    logic [4:0]  idRt = '0;
    logic        idUseRt = 1'b0;
    logic [5:0]  exOp = OP_B;
    logic [4:0]  exRt = '0;
    logic        exTaken = 1'b0;
    logic        memBusy = 1'b0;

    logic        pc1, bub1, fl1, hold1;
    logic [15:0] sc1, fc1;
    logic        pc3, bub3, fl3, hold3;
    logic [15:0] sc3, fc3;
    logic        pcS, bubS, flS, holdS;
    logic [3:0]  scS, fcS;

    int testsRun = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    de_hazard_ctrl #(.LOAD_STALLS(1), .CNT_W(16)) u_ls1 (
        .i_clk(clk), .i_rst(rst), .i_id_rs(idRs), .i_id_rt(idRt),
        .i_id_use_rt(idUseRt), .i_ex_op(exOp), .i_ex_rt(exRt),
        .i_ex_taken(exTaken), .i_mem_busy(memBusy),
        .o_pc_stall(pc1), .o_de_bubble(bub1), .o_fd_flush(fl1),
        .o_pipe_hold(hold1), .o_stall_cnt(sc1), .o_flush_cnt(fc1)
    );

    de_hazard_ctrl #(.LOAD_STALLS(3), .CNT_W(16)) u_ls3 (
        .i_clk(clk), .i_rst(rst), .i_id_rs(idRs), .i_id_rt(idRt),
        .i_id_use_rt(idUseRt), .i_ex_op(exOp), .i_ex_rt(exRt),
        .i_ex_taken(exTaken), .i_mem_busy(memBusy),
        .o_pc_stall(pc3), .o_de_bubble(bub3), .o_fd_flush(fl3),
        .o_pipe_hold(hold3), .o_stall_cnt(sc3), .o_flush_cnt(fc3)
    );

    de_hazard_ctrl #(.LOAD_STALLS(1), .CNT_W(4)) u_sat (
        .i_clk(clk), .i_rst(rst), .i_id_rs(idRs), .i_id_rt(idRt),
        .i_id_use_rt(idUseRt), .i_ex_op(exOp), .i_ex_rt(exRt),
        .i_ex_taken(exTaken), .i_mem_busy(memBusy),
        .o_pc_stall(pcS), .o_de_bubble(bubS), .o_fd_flush(flS),
        .o_pipe_hold(holdS), .o_stall_cnt(scS), .o_flush_cnt(fcS)
    );

    // Drive a new input set away from the rising edge and let the
    // combinational outputs settle before anything is sampled.
    task automatic applyStimulus(input logic r, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic useRt,
                                 input logic [5:0] op, input logic [4:0] xrt,
                                 input logic taken, input logic busy);
        @(negedge clk);
        rst     = r;
        idRs    = rs;
        idRt    = rt;
        idUseRt = useRt;
        exOp    = op;
        exRt    = xrt;
        exTaken = taken;
        memBusy = busy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        testsRun++;
        if (act != exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Inputs for an idle cycle and for the standard rs load-use hazard.
    task automatic idle(input logic r);
        applyStimulus(r, 5'd0, 5'd0, 1'b0, OP_B, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic hazardIn();
        applyStimulus(1'b0, 5'd5, 5'd0, 1'b0, OP_L, 5'd5, 1'b0, 1'b0);
    endtask

    task automatic resetAll();
        idle(1'b1);
        tick();
        idle(1'b1);
        tick();
    endtask

    vec_t vecs[$];

    initial begin
        // name, rst, rs, rt, useRt, op, exRt, taken, busy,
        // pc, bub, fl, hold, stall_cnt after edge, flush_cnt after edge
        vecs.push_back('{"reset0",      1, 0, 0, 0, OP_B,  0, 0, 0, 0, 1, 1, 0, 0, 0});
        vecs.push_back('{"reset1",      1, 0, 0, 0, OP_B,  0, 0, 0, 0, 1, 1, 0, 0, 0});
        vecs.push_back('{"idle",        0, 0, 0, 0, OP_B,  0, 0, 0, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{"lw_rs",       0, 5, 0, 0, OP_L,  5, 0, 0, 1, 1, 0, 0, 1, 0});
        vecs.push_back('{"after_lw",    0, 5, 0, 0, OP_B,  5, 0, 0, 0, 0, 0, 0, 1, 0});
        vecs.push_back('{"lw_r0",       0, 0, 0, 0, OP_L,  0, 0, 0, 0, 0, 0, 0, 1, 0});
        vecs.push_back('{"rt_unused",   0, 3, 7, 0, OP_L,  7, 0, 0, 0, 0, 0, 0, 1, 0});
        vecs.push_back('{"rt_used",     0, 3, 7, 1, OP_L,  7, 0, 0, 1, 1, 0, 0, 2, 0});
        vecs.push_back('{"non_load",    0, 5, 0, 0, OP_AD, 5, 0, 0, 0, 0, 0, 0, 2, 0});
        vecs.push_back('{"taken_haz",   0, 5, 0, 0, OP_L,  5, 1, 0, 0, 1, 1, 0, 2, 1});
        vecs.push_back('{"busy_all",    0, 5, 0, 0, OP_L,  5, 1, 1, 1, 0, 0, 1, 2, 1});
        vecs.push_back('{"taken",       0, 0, 0, 0, OP_B,  0, 1, 0, 0, 1, 1, 0, 2, 2});
        vecs.push_back('{"rst_haz",     1, 5, 0, 0, OP_L,  5, 1, 1, 0, 1, 1, 0, 0, 0});

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].rs, vecs[i].rt, vecs[i].useRt,
                          vecs[i].op, vecs[i].exRt, vecs[i].taken, vecs[i].busy);
            checkOutput({vecs[i].name, ".pc_stall"},  int'(pc1),   int'(vecs[i].expPc));
            checkOutput({vecs[i].name, ".de_bubble"}, int'(bub1),  int'(vecs[i].expBub));
            checkOutput({vecs[i].name, ".fd_flush"},  int'(fl1),   int'(vecs[i].expFl));
            checkOutput({vecs[i].name, ".pipe_hold"}, int'(hold1), int'(vecs[i].expHold));
            tick();
            checkOutput({vecs[i].name, ".stall_cnt"}, int'(sc1), vecs[i].expStall);
            checkOutput({vecs[i].name, ".flush_cnt"}, int'(fc1), vecs[i].expFlush);
        end

        // Three-cycle load-use stall, inputs drop the hazard after entry.
        resetAll();
        hazardIn();
        checkOutput("ls3.c1.pc_stall", int'(pc3), 1);
        checkOutput("ls3.c1.de_bubble", int'(bub3), 1);
        tick();
        idle(1'b0);
        checkOutput("ls3.c2.pc_stall", int'(pc3), 1);
        tick();
        idle(1'b0);
        checkOutput("ls3.c3.pc_stall", int'(pc3), 1);
        checkOutput("ls3.c3.de_bubble", int'(bub3), 1);
        tick();
        idle(1'b0);
        checkOutput("ls3.run.pc_stall", int'(pc3), 0);
        checkOutput("ls3.stall_cnt", int'(sc3), 3);

        // Taken branch in STALL aborts the remaining bubbles.
        resetAll();
        hazardIn();
        tick();
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, OP_B, 5'd0, 1'b1, 1'b0);
        checkOutput("abort.fd_flush", int'(fl3), 1);
        checkOutput("abort.de_bubble", int'(bub3), 1);
        checkOutput("abort.pc_stall", int'(pc3), 0);
        tick();
        checkOutput("abort.stall_cnt", int'(sc3), 1);
        checkOutput("abort.flush_cnt", int'(fc3), 1);
        idle(1'b0);
        checkOutput("abort.run.pc_stall", int'(pc3), 0);

        // Memory wait for 4 cycles while two bubbles remain.
        resetAll();
        hazardIn();
        tick();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, OP_B, 5'd0, 1'b0, 1'b1);
            checkOutput($sformatf("busy%0d.pipe_hold", k), int'(hold3), 1);
            checkOutput($sformatf("busy%0d.pc_stall", k), int'(pc3), 1);
            checkOutput($sformatf("busy%0d.de_bubble", k), int'(bub3), 0);
            tick();
            checkOutput($sformatf("busy%0d.stall_cnt", k), int'(sc3), 1);
        end
        idle(1'b0);
        checkOutput("resume1.pc_stall", int'(pc3), 1);
        tick();
        idle(1'b0);
        checkOutput("resume2.pc_stall", int'(pc3), 1);
        tick();
        idle(1'b0);
        checkOutput("resume.run.pc_stall", int'(pc3), 0);
        checkOutput("resume.stall_cnt", int'(sc3), 3);
        checkOutput("resume.flush_cnt", int'(fc3), 0);

        // Reset in the middle of a stall returns to RUN with cleared counters.
        resetAll();
        hazardIn();
        tick();
        idle(1'b1);
        checkOutput("rstmid.pc_stall", int'(pc3), 0);
        checkOutput("rstmid.fd_flush", int'(fl3), 1);
        tick();
        checkOutput("rstmid.stall_cnt", int'(sc3), 0);
        idle(1'b0);
        checkOutput("rstmid.run.pc_stall", int'(pc3), 0);

        // Twenty flushes into a 4-bit counter stop at 15.
        resetAll();
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, OP_B, 5'd0, 1'b1, 1'b0);
            tick();
            checkOutput($sformatf("sat%0d.flush_cnt", k), int'(fcS), (k > 15) ? 15 : k);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
